slot_output_mixer: RTL and testbench



---
 rtl/slot_output_mixer.sv | 147 ++++++++++++++
 tb/tb_slot_output_mixer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/slot_output_mixer.sv
// Per-frame scan of the operator output memory: sums carrier slot outputs into
// signed melody and rhythm totals and publishes them with a one-cycle strobe.
module slot_output_mixer #(
  parameter int NUM_SLOTS = 18,
  parameter int MAG_W     = 9,
  parameter int ACC_W     = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    rhythm,
  output logic [4:0]              rd_addr,
  input  logic                    rd_sign,
  input  logic [MAG_W-1:0]        rd_mag,
  output logic signed [ACC_W-1:0] melody_out,
  output logic signed [ACC_W-1:0] rhythm_out,
  output logic                    out_valid,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

  localparam logic [4:0] LAST_SLOT  = 5'(NUM_SLOTS - 1);
  localparam logic [4:0] WAIT_LAST  = 5'd2;
  localparam logic [4:0] LAST_CHAN5 = 5'd11;
  localparam logic [4:0] BD_SLOT    = 5'd13;
  localparam logic [4:0] HH_SLOT    = 5'd14;

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    rhy_lat_q, rhy_lat_d;
  logic                    tag_vld_q, tag_vld_d;
  logic [4:0]              tag_q, tag_d;
  logic signed [ACC_W-1:0] mel_acc_q, mel_acc_d;
  logic signed [ACC_W-1:0] rhy_acc_q, rhy_acc_d;
  logic signed [ACC_W-1:0] melody_q, melody_d;
  logic signed [ACC_W-1:0] rhythm_q, rhythm_d;
  logic                    valid_q, valid_d;

  logic signed [ACC_W-1:0] mag_ext, slot_val;
  logic                    to_mel, to_rhy, publish;

  // State register and all datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rhy_lat_q <= 1'b0;
      tag_vld_q <= 1'b0;
      tag_q     <= '0;
      mel_acc_q <= '0;
      rhy_acc_q <= '0;
      melody_q  <= '0;
      rhythm_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rhy_lat_q <= rhy_lat_d;
      tag_vld_q <= tag_vld_d;
      tag_q     <= tag_d;
      mel_acc_q <= mel_acc_d;
      rhy_acc_q <= rhy_acc_d;
      melody_q  <= melody_d;
      rhythm_q  <= rhythm_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state logic; WAIT covers the read latency plus the final accumulate
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = SCAN;
      end
      SCAN: begin
        if (cnt_q == LAST_SLOT) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign publish = (state_q == WAIT) && (cnt_q == WAIT_LAST);

  // Sign-magnitude to two's complement; negative zero negates to zero
  assign mag_ext  = {{(ACC_W-MAG_W){1'b0}}, rd_mag};
  assign slot_val = rd_sign ? -mag_ext : mag_ext;

  // Only carriers (odd slots) are summed; rhythm mode steals channels 6-8
  assign to_mel = tag_q[0] && (!rhy_lat_q || tag_q <= LAST_CHAN5);
  assign to_rhy = rhy_lat_q && ((tag_q == BD_SLOT) || (tag_q >= HH_SLOT));

  always_comb begin
    rhy_lat_d = rhy_lat_q;
    tag_vld_d = (state_q == SCAN);
    tag_d     = cnt_q;
    mel_acc_d = mel_acc_q;
    rhy_acc_d = rhy_acc_q;
    melody_d  = melody_q;
    rhythm_d  = rhythm_q;
    valid_d   = publish;
    if (state_q == IDLE && start) begin
      rhy_lat_d = rhythm;
      mel_acc_d = '0;
      rhy_acc_d = '0;
    end else if (tag_vld_q) begin
      if (to_mel) mel_acc_d = mel_acc_q + slot_val;
      if (to_rhy) rhy_acc_d = rhy_acc_q + slot_val;
    end
    if (publish) begin
      melody_d = mel_acc_q;
      rhythm_d = rhy_acc_q;
    end
  end

  // Output logic
  always_comb begin
    rd_addr = '0;
    case (state_q)
      SCAN:    rd_addr = cnt_q;
      WAIT:    rd_addr = LAST_SLOT;
      default: rd_addr = '0;
    endcase
  end

  assign melody_out = melody_q;
  assign rhythm_out = rhythm_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_slot_output_mixer.sv
// Directed bench for slot_output_mixer with a registered-read output memory model.
module tb_slot_output_mixer;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               rhythm = 1'b0;
  logic [4:0]         rd_addr;
  logic               rd_sign = 1'b0;
  logic [8:0]         rd_mag = '0;
  logic signed [13:0] melody_out;
  logic signed [13:0] rhythm_out;
  logic               out_valid;
  logic               busy;

  logic       mem_sign [18];
  logic [8:0] mem_mag  [18];

  int checks = 0;
  int failures = 0;

  slot_output_mixer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rhythm     (rhythm),
    .rd_addr    (rd_addr),
    .rd_sign    (rd_sign),
    .rd_mag     (rd_mag),
    .melody_out (melody_out),
    .rhythm_out (rhythm_out),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Registered read port: data follows the edge that samples rd_addr
  always @(posedge clk) begin
    if (rd_addr < 5'd18) begin
      rd_sign <= mem_sign[rd_addr];
      rd_mag  <= mem_mag[rd_addr];
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic s, input int m);
    for (int i = 0; i < 18; i++) begin
      mem_sign[i] = s;
      mem_mag[i]  = 9'(m);
    end
  endtask

  // One frame: start accepted on the next edge; observe 40 cycles after it
  task automatic run_frame(input logic rh, output int lat, output int busy_cyc,
                           output int pulses);
    lat = -1; busy_cyc = 0; pulses = 0;
    @(negedge clk);
    start = 1'b1;
    rhythm = rh;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (out_valid) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
    $display("frame rhythm=%0d latency=%0d busy=%0d pulses=%0d melody=%0d rhythm_sum=%0d",
             rh, lat, busy_cyc, pulses, melody_out, rhythm_out);
  endtask

  int lat, bc, np, c, k;
  int pc [3];
  int pm [3];

  initial begin
    set_all(1'b0, 0);
    repeat (3) @(negedge clk);
    check("reset_melody", int'(melody_out), 0);
    check("reset_rhythm", int'(rhythm_out), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_addr", int'(rd_addr), 0);
    reset = 1'b0;

    // 1: full-scale positive, melody mode
    set_all(1'b0, 511);
    run_frame(1'b0, lat, bc, np);
    check("t1_latency", lat, 21);
    check("t1_busy", bc, 22);
    check("t1_pulses", np, 1);
    check("t1_melody", int'(melody_out), 4599);
    check("t1_rhythm", int'(rhythm_out), 0);

    // 2: rhythm mode routing, slot 12 ignored
    set_all(1'b0, 100);
    run_frame(1'b1, lat, bc, np);
    check("t2_melody", int'(melody_out), 600);
    check("t2_rhythm", int'(rhythm_out), 500);
    mem_mag[12] = 9'd511;
    run_frame(1'b1, lat, bc, np);
    check("t2_s12_melody", int'(melody_out), 600);
    check("t2_s12_rhythm", int'(rhythm_out), 500);

    // 3: alternating signs on carriers, modulators full-scale
    for (int i = 0; i < 18; i++) begin
      mem_sign[i] = (i % 4 == 3);
      mem_mag[i]  = (i % 2 == 1) ? 9'd300 : 9'd511;
    end
    run_frame(1'b0, lat, bc, np);
    check("t3_melody", int'(melody_out), 300);
    mem_sign[5] = 1'b1;
    mem_mag[5]  = 9'd0;
    run_frame(1'b0, lat, bc, np);
    check("t3_negzero", int'(melody_out), 0);

    // 4: spurious starts and rhythm toggling inside a frame
    set_all(1'b0, 100);
    np = 0;
    @(negedge clk);
    start = 1'b1;
    rhythm = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) np++;
      start  = (i == 3 || i == 10 || i == 20);
      rhythm = ~rhythm;
    end
    start = 1'b0;
    $display("frame spurious-start pulses=%0d melody=%0d rhythm_sum=%0d", np, melody_out, rhythm_out);
    check("t4_pulses", np, 1);
    check("t4_melody", int'(melody_out), 900);
    check("t4_rhythm", int'(rhythm_out), 0);

    // 5: reset at cycle 8 of a scan
    @(negedge clk);
    start = 1'b1;
    rhythm = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_melody", int'(melody_out), 0);
    check("t5_rhythm", int'(rhythm_out), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_valid", int'(out_valid), 0);
    check("t5_addr", int'(rd_addr), 0);
    reset = 1'b0;
    np = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) np++;
    end
    $display("reset abort pulses_after=%0d", np);
    check("t5_no_pulse", np, 0);
    run_frame(1'b1, lat, bc, np);
    check("t5_post_melody", int'(melody_out), 600);
    check("t5_post_rhythm", int'(rhythm_out), 500);

    // 6: back-to-back frames with start held, new data per frame
    set_all(1'b0, 511);
    k = 0;
    @(negedge clk);
    start = 1'b1;
    rhythm = 1'b0;
    for (c = 0; c < 120 && k < 3; c++) begin
      @(negedge clk);
      if (out_valid) begin
        pc[k] = c;
        pm[k] = int'(melody_out);
        $display("b2b frame=%0d cycle=%0d melody=%0d", k, c, melody_out);
        if (k == 0) set_all(1'b0, 1);
        if (k == 1) set_all(1'b1, 7);
        k++;
        if (k == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("t6_frames", k, 3);
    if (k == 3) begin
      check("t6_period1", pc[1] - pc[0], 23);
      check("t6_period2", pc[2] - pc[1], 23);
      check("t6_melody0", pm[0], 4599);
      check("t6_melody1", pm[1], 9);
      check("t6_melody2", pm[2], -63);
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
